// File: rtl/bpm_tracker.sv
// bpm_tracker: tempo estimator turning beat pulses into a BPM value.
// Mode 0 counts debounced hits over a fixed window; mode 1 times the
// beat-to-beat interval and converts it with a serial restoring divider.
module bpm_tracker #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned WINDOW_DIV     = 4,
  parameter int unsigned BPM_W          = 8,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_BPM    = 120,
  parameter int unsigned MIN_BPM        = 30,
  parameter int unsigned MAX_BPM        = 240,
  parameter int unsigned REFRACT_CYCLES = CLK_HZ / 20
) (
  input  logic             clk_camera_in,
  input  logic             rst_in,
  input  logic             change_in,
  input  logic [BPM_W-1:0] bpm_in,
  input  logic             valid_override_in,
  input  logic             measure_in,
  input  logic             mode_in,
  output logic [BPM_W-1:0] bpm_out,
  output logic             bpm_valid_out,
  output logic             busy_out
);

  localparam longint unsigned CYC_PER_MIN_L   = 64'(CLK_HZ) * 64'd60;
  localparam longint unsigned WINDOW_CYCLES_L = CYC_PER_MIN_L / 64'(WINDOW_DIV);
  localparam longint unsigned TIMEOUT_L       = CYC_PER_MIN_L / 64'(MIN_BPM);
  localparam int unsigned     STEP_W          = $clog2(CNT_W);

  localparam logic [CNT_W-1:0]  CYC_PER_MIN = CNT_W'(CYC_PER_MIN_L);
  localparam logic [CNT_W-1:0]  WINDOW_LAST = CNT_W'(WINDOW_CYCLES_L - 64'd1);
  localparam logic [CNT_W-1:0]  TIMEOUT     = CNT_W'(TIMEOUT_L);
  localparam logic [CNT_W-1:0]  REFRACT     = CNT_W'(REFRACT_CYCLES);
  localparam logic [CNT_W-1:0]  MIN_C       = CNT_W'(MIN_BPM);
  localparam logic [CNT_W-1:0]  MAX_C       = CNT_W'(MAX_BPM);
  localparam logic [BPM_W-1:0]  MIN_B       = BPM_W'(MIN_BPM);
  localparam logic [BPM_W-1:0]  MAX_B       = BPM_W'(MAX_BPM);
  localparam logic [BPM_W-1:0]  DEFAULT_B   = BPM_W'(DEFAULT_BPM);
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(CNT_W - 1);

  typedef enum logic [2:0] {IDLE, WINDOW, ARM, TIMING, DIVIDE, UPDATE} state_e;

  state_e             state_q, state_d;
  logic               change_prev_q, change_prev_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   refr_q, refr_d;
  logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [BPM_W-1:0]   hits_q, hits_d;
  logic [CNT_W-1:0]   ivl_q, ivl_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   quo_q, quo_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [BPM_W-1:0]   bpm_q, bpm_d;
  logic               valid_q, valid_d;

  logic               hit;
  logic               abort;
  logic               win_end;
  logic               div_last;
  logic [CNT_W:0]     rem_sh;
  logic [CNT_W:0]     diff;
  logic [CNT_W-1:0]   win_prod;

  function automatic logic [BPM_W-1:0] clamp_bpm(input logic [CNT_W-1:0] x);
    logic [BPM_W-1:0] r;
    if (x < MIN_C)      r = MIN_B;
    else if (x > MAX_C) r = MAX_B;
    else                r = x[BPM_W-1:0];
    return r;
  endfunction

  // Hit detection and mode-exit conditions shared by all processes
  always_comb begin
    hit   = change_in && !change_prev_q && (refr_q == '0);
    abort = !measure_in || (mode_in != mode_q);
  end

  // State and datapath registers
  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      change_prev_q <= 1'b0;
      mode_q        <= 1'b0;
      refr_q        <= '0;
      win_cnt_q     <= '0;
      hits_q        <= '0;
      ivl_q         <= '0;
      div_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      step_q        <= '0;
      bpm_q         <= DEFAULT_B;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      change_prev_q <= change_prev_d;
      mode_q        <= mode_d;
      refr_q        <= refr_d;
      win_cnt_q     <= win_cnt_d;
      hits_q        <= hits_d;
      ivl_q         <= ivl_d;
      div_q         <= div_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      step_q        <= step_d;
      bpm_q         <= bpm_d;
      valid_q       <= valid_d;
    end
  end

  // Next-state logic: override and mode exits pre-empt the FSM
  always_comb begin
    state_d = state_q;
    if (valid_override_in || abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = mode_in ? ARM : WINDOW;
        WINDOW:  state_d = WINDOW;
        ARM:     if (hit) state_d = TIMING;
        TIMING: begin
          if (hit)                           state_d = DIVIDE;
          else if ((ivl_q + 1'b1) >= TIMEOUT) state_d = ARM;
        end
        DIVIDE:  if (div_last) state_d = UPDATE;
        UPDATE:  state_d = TIMING;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM-decoded outputs and qualifiers
  always_comb begin
    busy_out = (state_q == DIVIDE);
    win_end  = (state_q == WINDOW) && (win_cnt_q == WINDOW_LAST);
    div_last = (state_q == DIVIDE) && (step_q == LAST_STEP);
  end

  // Datapath: refractory, window counting, interval timing, divider, result
  always_comb begin
    change_prev_d = change_in;
    mode_d        = mode_in;
    refr_d        = refr_q;
    win_cnt_d     = win_cnt_q;
    hits_d        = hits_q;
    ivl_d         = ivl_q;
    div_d         = div_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    step_d        = step_q;
    bpm_d         = bpm_q;
    valid_d       = 1'b0;
    rem_sh        = {rem_q, quo_q[CNT_W-1]};
    diff          = rem_sh - {1'b0, div_q};
    win_prod      = CNT_W'(hits_q) * CNT_W'(WINDOW_DIV);

    if (hit)                refr_d = REFRACT;
    else if (refr_q != '0)  refr_d = refr_q - 1'b1;

    if (valid_override_in || abort) begin
      if (valid_override_in) begin
        bpm_d   = bpm_in;
        valid_d = 1'b1;
      end
      win_cnt_d = '0;
      hits_d    = '0;
      ivl_d     = '0;
      step_d    = '0;
    end else begin
      case (state_q)
        WINDOW: begin
          if (win_end) begin
            // a hit on the closing cycle belongs to the next window
            bpm_d     = clamp_bpm(win_prod);
            valid_d   = 1'b1;
            win_cnt_d = '0;
            hits_d    = hit ? BPM_W'(1) : '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            if (hit && (hits_q != '1)) hits_d = hits_q + 1'b1;
          end
        end
        ARM: begin
          if (hit) ivl_d = '0;
        end
        TIMING: begin
          if (hit) begin
            div_d  = ivl_q + 1'b1;
            ivl_d  = '0;
            rem_d  = '0;
            quo_d  = CYC_PER_MIN;
            step_d = '0;
          end else begin
            ivl_d = ivl_q + 1'b1;
          end
        end
        DIVIDE, UPDATE: begin
          // interval keeps timing so the next beat is measured from the last one
          if (hit)                  ivl_d = '0;
          else if (ivl_q < TIMEOUT) ivl_d = ivl_q + 1'b1;
          if (state_q == DIVIDE) begin
            step_d = step_q + 1'b1;
            if (!diff[CNT_W]) begin
              rem_d = diff[CNT_W-1:0];
              quo_d = {quo_q[CNT_W-2:0], 1'b1};
            end else begin
              rem_d = rem_sh[CNT_W-1:0];
              quo_d = {quo_q[CNT_W-2:0], 1'b0};
            end
          end else begin
            bpm_d   = clamp_bpm(quo_q);
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bpm_out       = bpm_q;
  assign bpm_valid_out = valid_q;

endmodule

// File: tb/tb_bpm_tracker.sv
// tb_bpm_tracker: directed bench for bpm_tracker with CLK_HZ=1000,
// REFRACT_CYCLES=50 (window 15000 cycles, timeout 2000 cycles).
module tb_bpm_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       change;
  logic [7:0] bpm_in;
  logic       ovr;
  logic       measure;
  logic       mode;
  logic [7:0] bpm_out;
  logic       bpm_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  bpm_tracker #(
    .CLK_HZ(1000),
    .WINDOW_DIV(4),
    .BPM_W(8),
    .CNT_W(32),
    .DEFAULT_BPM(120),
    .MIN_BPM(30),
    .MAX_BPM(240),
    .REFRACT_CYCLES(50)
  ) dut (
    .clk_camera_in(clk),
    .rst_in(rst),
    .change_in(change),
    .bpm_in(bpm_in),
    .valid_override_in(ovr),
    .measure_in(measure),
    .mode_in(mode),
    .bpm_out(bpm_out),
    .bpm_valid_out(bpm_valid),
    .busy_out(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ovr;
    logic [7:0] bin;
    logic [7:0] exp_bpm;
    logic       exp_valid;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one full window from cnt 0; hits at start+step*j, optional hit on last cycle
  task automatic run_window(input int n, input int start, input int step,
                            input bit extra_last, input int exp_bpm);
    int early = 0;
    int at_end = 0;
    for (int w = 0; w < 15000; w++) begin
      change = 1'b0;
      for (int j = 0; j < n; j++) if (w == start + step * j) change = 1'b1;
      if (extra_last && w == 14999) change = 1'b1;
      tick();
      if (w < 14999 && bpm_valid) early++;
      if (w == 14999) at_end = bpm_valid;
    end
    change = 1'b0;
    chk("win_no_early_valid", early, 0);
    chk("win_valid_at_end", at_end, 1);
    chk("win_bpm", bpm_out, exp_bpm);
  endtask

  // Hit in TIMING; checks divider busy span, 34-cycle latency and result
  task automatic hit_check(input string name, input int exp_bpm, input bit bounce,
                           input int ticks_after);
    int verr = 0;
    int berr = 0;
    int extra = 0;
    change = 1'b1;
    tick();
    change = 1'b0;
    chk({name, "_busy_start"}, busy, 1);
    for (int i = 1; i <= 33; i++) begin
      if (bounce && i == 10) change = 1'b1;
      if (bounce && i == 11) change = 1'b0;
      tick();
      if (bpm_valid != (i == 33)) verr++;
      if (busy != (i <= 31)) berr++;
    end
    chk({name, "_valid_timing"}, verr, 0);
    chk({name, "_busy_span"}, berr, 0);
    chk({name, "_bpm"}, bpm_out, exp_bpm);
    for (int i = 34; i <= ticks_after; i++) begin
      tick();
      if (bpm_valid) extra++;
    end
    chk({name, "_no_extra_valid"}, extra, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; change = 1'b0; bpm_in = '0; ovr = 1'b0; measure = 1'b0; mode = 1'b0;
    vt[0] = '{1'b1, 8'd250, 8'd250, 1'b1};
    vt[1] = '{1'b1, 8'd10,  8'd10,  1'b1};
    vt[2] = '{1'b0, 8'd99,  8'd10,  1'b0};
    vt[3] = '{1'b1, 8'd77,  8'd77,  1'b1};
    vt[4] = '{1'b0, 8'd0,   8'd77,  1'b0};
    vt[5] = '{1'b0, 8'd200, 8'd77,  1'b0};

    tick(); tick();
    chk("reset_bpm", bpm_out, 120);
    chk("reset_valid", bpm_valid, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    // Override table: unclamped load, back-to-back pulses, hold afterwards
    foreach (vt[i]) begin
      ovr = vt[i].ovr; bpm_in = vt[i].bin;
      tick();
      chk($sformatf("ovr_vec%0d_bpm", i), bpm_out, vt[i].exp_bpm);
      chk($sformatf("ovr_vec%0d_valid", i), bpm_valid, vt[i].exp_valid);
    end
    ovr = 1'b0;

    // Window mode: 30 hits -> 120, plus a hit on the closing cycle carried over
    measure = 1'b1; mode = 1'b0;
    tick();
    run_window(30, 10, 500, 1'b1, 120);
    run_window(7, 500, 1000, 1'b0, 32);

    // Reset mid-window after 10 hits; next window starts from zero hits
    measure = 1'b0; tick();
    measure = 1'b1; tick();
    for (int w = 0; w <= 1000; w++) begin
      change = (w % 100 == 50) && (w < 1000);
      tick();
    end
    change = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_bpm", bpm_out, 120);
    chk("midrst_valid", bpm_valid, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    tick();
    run_window(3, 100, 100, 1'b0, 30);

    // Interval mode
    measure = 1'b0; mode = 1'b1; tick();
    measure = 1'b1; tick(); tick();
    change = 1'b1; tick(); change = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 499; i++) begin tick(); if (bpm_valid || busy) cnt++; end
    chk("arm_first_hit_quiet", cnt, 0);
    hit_check("ivl500a", 120, 1'b0, 499);
    hit_check("ivl500b", 120, 1'b0, 99);
    hit_check("ivl100a", 240, 1'b0, 99);
    hit_check("ivl100b", 240, 1'b0, 2099);

    // After timeout: next hit only re-arms; bounce 10 cycles later is rejected
    change = 1'b1; tick(); change = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 999; i++) begin
      if (i == 10) change = 1'b1;
      if (i == 11) change = 1'b0;
      tick();
      if (bpm_valid || busy) cnt++;
    end
    chk("timeout_rearm_quiet", cnt, 0);
    chk("timeout_bpm_held", bpm_out, 240);
    hit_check("bounce1000a", 60, 1'b1, 999);
    hit_check("bounce1000b", 60, 1'b1, 999);

    // Override in the middle of a division
    change = 1'b1; tick(); change = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    chk("mid_div_busy", busy, 1);
    ovr = 1'b1; bpm_in = 8'd90;
    tick();
    ovr = 1'b0;
    chk("abort_bpm", bpm_out, 90);
    chk("abort_valid", bpm_valid, 1);
    chk("abort_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (bpm_valid || busy) cnt++; end
    chk("abort_no_late_update", cnt, 0);
    chk("abort_bpm_held", bpm_out, 90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
